// File: rtl/mul32_seq_ctrl.sv
// Sequential 32x32 unsigned multiplier: four 16x16 partials through one shared Vedic core.
// Define MUL_SEQ_ACC_EN to keep a running sum across transactions (adds the acc_clr port).

module Vedic_mul_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] ll, lh, hl, hh;
  logic [16:0] mid;

  // Urdhva-tiryagbhyam on 8-bit digits: vertical terms at the ends, crosswise sum in the middle.
  assign ll  = a[7:0]  * b[7:0];
  assign lh  = a[7:0]  * b[15:8];
  assign hl  = a[15:8] * b[7:0];
  assign hh  = a[15:8] * b[15:8];
  assign mid = {1'b0, lh} + {1'b0, hl};
  assign p   = {hh, ll} + {7'b0, mid, 8'b0};
endmodule

module mul32_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef MUL_SEQ_ACC_EN
  input  logic        acc_clr,
`endif
  output logic [63:0] out,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [15:0] ma, mb;
  logic [31:0] prod;
  logic [63:0] partial;
  logic        accept;

  Vedic_mul_16x16 u_core (
    .a (ma),
    .b (mb),
    .p (prod)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        accept   = in_valid;
        if (in_valid) state_d = P0;
      end
      P0:   state_d = P1;
      P1:   state_d = P2;
      P2:   state_d = P3;
      P3:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ma      = a_q[15:0];
    mb      = b_q[15:0];
    partial = {32'b0, prod};
    case (state_q)
      P1: begin
        ma      = a_q[31:16];
        partial = {16'b0, prod, 16'b0};
      end
      P2: begin
        mb      = b_q[31:16];
        partial = {16'b0, prod, 16'b0};
      end
      P3: begin
        ma      = a_q[31:16];
        mb      = b_q[31:16];
        partial = {prod, 32'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q <= a;
            b_q <= b;
          end
`ifdef MUL_SEQ_ACC_EN
          if (acc_clr) acc_q <= '0;
`else
          if (accept) acc_q <= '0;
`endif
        end
        P0, P1, P2, P3: acc_q <= acc_q + partial;
        default: ;
      endcase
    end
  end

  assign out = acc_q;
endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Directed bench for mul32_seq_ctrl: latency, backpressure, abort, issue rate and optional accumulate mode.

module tb_mul32_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out;
  logic        busy;
`ifdef MUL_SEQ_ACC_EN
  logic        acc_clr = 1'b0;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  mul32_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUL_SEQ_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Issues one operand pair from IDLE, scrambles a/b right after the accept, then
  // waits (bounded) for out_valid. lat counts edges after the accept edge.
  task automatic run_txn(input logic [31:0] xa, input logic [31:0] xb,
                         output int lat, output logic [63:0] prod);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 64'd0)      begin n_bad++; $display("FAIL reset_out got %h want 0", out); end
  endtask

  task automatic test_max;
    int lat;
    logic [63:0] p;
    out_ready = 1'b1;
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p);
    // out_valid rises after the 4th edge, so the consumer samples it at accept+5.
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL max_latency got %0d want 4", lat); end
    n_cmp++; if (p !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL max_out got %h want fffffffe00000001", p); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL max_held_one got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL max_back_idle got %b want 1", in_ready); end
  endtask

  task automatic test_vectors;
    logic [31:0] va [3] = '{32'h0001_0000, 32'h0000_0000, 32'hDEAD_BEEF};
    logic [31:0] vb [3] = '{32'h0001_0000, 32'h1234_5678, 32'h0000_0001};
    logic [63:0] ve [3] = '{64'h0000_0001_0000_0000, 64'h0, 64'h0000_0000_DEAD_BEEF};
    int lat;
    logic [63:0] p;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_txn(va[i], vb[i], lat, p);
      n_cmp++; if (p !== ve[i]) begin n_bad++; $display("FAIL vec%0d_out got %h want %h", i, p, ve[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [63:0] p;
    out_ready = 1'b0;
    run_txn(32'h0000_ABCD, 32'h0000_1234, lat, p);
    n_cmp++; if (p !== 64'h0000_0000_0C37_4FA4) begin n_bad++; $display("FAIL bp_out got %h want 000000000c374fa4", p); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 64'h0000_0000_0C37_4FA4 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold%0d got v=%b out=%h ir=%b busy=%b want v=1 out=000000000c374fa4 ir=0 busy=1",
                 i, out_valid, out, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_release got ir=%b busy=%b v=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_abort;
    int lat;
    logic [63:0] p;
    out_ready = 1'b1;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk); #1;   // accept -> P0
    in_valid = 1'b0;
    @(posedge clk); #1;   // P1
    @(posedge clk); #1;   // P2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 64'd0) begin
      n_bad++; $display("FAIL abort_state got v=%b ir=%b out=%h want 0 1 0", out_valid, in_ready, out);
    end
    run_txn(32'd3, 32'd7, lat, p);
    n_cmp++; if (p !== 64'd21) begin n_bad++; $display("FAIL abort_next got %0d want 21", p); end
    @(posedge clk); #1;
  endtask

`ifdef MUL_SEQ_ACC_EN
  task automatic test_acc;
    int lat;
    logic [63:0] p;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    run_txn(32'd2, 32'd3, lat, p);
    acc_clr = 1'b0;
    n_cmp++; if (p !== 64'd6) begin n_bad++; $display("FAIL acc_first got %h want 6", p); end
    @(posedge clk); #1;
    run_txn(32'd4, 32'd5, lat, p);
    n_cmp++; if (p !== 64'h1A) begin n_bad++; $display("FAIL acc_sum got %h want 1a", p); end
    @(posedge clk); #1;
    acc_clr = 1'b1;
    run_txn(32'd6, 32'd7, lat, p);
    acc_clr = 1'b0;
    n_cmp++; if (p !== 64'h2A) begin n_bad++; $display("FAIL acc_clr got %h want 2a", p); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back;
    logic [31:0] xa, xb;
    logic [63:0] exp;
    int gap;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    for (int t = 0; t < 100; t++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d got %b want 1", t, in_ready); end
      xa = a;
      xb = b;
      exp = {32'b0, xa} * {32'b0, xb};
      @(posedge clk); #1;   // accept edge
      a = $urandom;
      b = $urandom;
      gap = 1;
      while (!out_valid && gap < 20) begin
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          n_cmp++; n_bad++;
          $display("FAIL b2b_accept_outside_idle%0d got ir=%b busy=%b want 0 1", t, in_ready, busy);
        end
        @(posedge clk); #1;
        gap++;
      end
      n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL b2b_out%0d got %h want %h", t, out, exp); end
      @(posedge clk); #1;   // product handshake -> IDLE
      gap++;
      // Accept at N, DONE from N+4, handshake at N+5, next accept at N+6.
      n_cmp++; if (gap !== 6) begin n_bad++; $display("FAIL b2b_rate%0d got %0d want 6", t, gap); end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_max();
    test_vectors();
    test_backpressure();
    test_abort();
`ifdef MUL_SEQ_ACC_EN
    test_acc();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
